// File: rtl/prog_inst_mem_if.sv
// Load-stream and fetch signal bundle for prog_inst_mem.
interface prog_inst_mem_if #(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned MEM_SIZE      = 1024,
  parameter int unsigned MEM_CELL_SIZE = 8
);
  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = 4 * MEM_CELL_SIZE;

  logic                     load_start;
  logic [WORD_SIZE-1:0]     load_base;
  logic [LW-1:0]            load_len;
  logic                     load_valid;
  logic [MEM_CELL_SIZE-1:0] load_byte;
  logic                     load_ready;
  logic                     load_done;
  logic                     busy;
  logic                     fetch_req;
  logic [WORD_SIZE-1:0]     fetch_addr;
  logic                     fetch_valid;
  logic [IW-1:0]            instruction;
  logic                     fetch_misaligned;

  modport master (
    output load_start, load_base, load_len, load_valid, load_byte,
    output fetch_req, fetch_addr,
    input  load_ready, load_done, busy,
    input  fetch_valid, instruction, fetch_misaligned
  );

  modport slave (
    input  load_start, load_base, load_len, load_valid, load_byte,
    input  fetch_req, fetch_addr,
    output load_ready, load_done, busy,
    output fetch_valid, instruction, fetch_misaligned
  );
endinterface

// File: rtl/prog_inst_mem.sv
// Byte-addressed little-endian instruction memory with streaming loader and registered fetch.
module prog_inst_mem #(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned MEM_SIZE      = 1024,
  parameter int unsigned MEM_CELL_SIZE = 8,
  parameter logic [4*MEM_CELL_SIZE-1:0] BOOT_WORD = 32'h8020000A
) (
  input logic            clk,
  input logic            rst,
  prog_inst_mem_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = MEM_CELL_SIZE;
  localparam int unsigned IW = 4 * CW;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic [LW-1:0] remaining, remaining_next;
  logic          wr_en_c;
  logic [CW-1:0] mem [MEM_SIZE];
  logic [AW-1:0] fa;
  logic [IW-1:0] word_c;
  logic          unused_addr_hi;

  assign fa     = bus.fetch_addr[AW-1:0];
  assign word_c = {mem[fa + AW'(3)], mem[fa + AW'(2)], mem[fa + AW'(1)], mem[fa]};
  assign unused_addr_hi = ^{bus.load_base[WORD_SIZE-1:AW], bus.fetch_addr[WORD_SIZE-1:AW]};

  // Loader next-state, pointer/count update and write strobe.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    remaining_next = remaining;
    wr_en_c        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          if (bus.load_len != '0) begin
            state_next     = LOAD;
            ptr_next       = bus.load_base[AW-1:0];
            remaining_next = bus.load_len;
          end else begin
            state_next = DONE;
          end
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          wr_en_c        = 1'b1;
          ptr_next       = ptr + AW'(1);
          remaining_next = remaining - LW'(1);
          if (remaining == LW'(1)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Loader bookkeeping and status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= '0;
      remaining      <= '0;
      bus.load_ready <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      ptr            <= ptr_next;
      remaining      <= remaining_next;
      bus.load_ready <= (state_next == LOAD);
      bus.load_done  <= (state_next == DONE);
      bus.busy       <= (state_next != IDLE);
    end
  end

  // Storage: boot word restored on reset, other cells keep their contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[AW'(i)] <= BOOT_WORD[i*CW +: CW];
    end else if (wr_en_c) begin
      mem[ptr] <= bus.load_byte;
    end
  end

  // Registered fetch port; requests while busy are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fetch_valid      <= 1'b0;
      bus.instruction      <= '0;
      bus.fetch_misaligned <= 1'b0;
    end else begin
      bus.fetch_valid <= bus.fetch_req && !bus.busy;
      if (bus.fetch_req && !bus.busy) begin
        bus.instruction      <= word_c;
        bus.fetch_misaligned <= (bus.fetch_addr[1:0] != 2'b00);
      end
    end
  end
endmodule

// File: tb/tb_prog_inst_mem.sv
// Self-checking bench for prog_inst_mem against a byte-array memory model.
module tb_prog_inst_mem;
  localparam int MS = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_inst_mem_if #(.WORD_SIZE(32), .MEM_SIZE(MS), .MEM_CELL_SIZE(8)) bus ();
  prog_inst_mem #(.WORD_SIZE(32), .MEM_SIZE(MS), .MEM_CELL_SIZE(8),
                  .BOOT_WORD(32'h8020000A)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [7:0] model [MS];
  bit         known [MS];
  logic [7:0] lq [$];
  int         fq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = model[(a + k) % MS];
    return w;
  endfunction

  function automatic logic [31:0] exp_mask(input int a);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = known[(a + k) % MS] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic boot_model();
    model[0] = 8'h0A; model[1] = 8'h00; model[2] = 8'h20; model[3] = 8'h80;
    for (int i = 0; i < 4; i++) known[i] = 1'b1;
  endtask

  // Back-to-back fetches of every address in fq, one per cycle.
  task automatic fetch_queue(input string tag);
    int a;
    logic [31:0] m;
    while (fq.size() > 0) begin
      a = fq.pop_front();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'(a);
      tick();
      m = exp_mask(a);
      chk({tag, "_valid"}, 32'(bus.fetch_valid), 32'd1);
      chk({tag, "_instr"}, bus.instruction & m, exp_word(a) & m);
      chk({tag, "_misal"}, 32'(bus.fetch_misaligned), 32'((a % 4) != 0));
    end
    bus.fetch_req = 1'b0;
  endtask

  // Stream a load; bytes come from lq if filled, otherwise random.
  task automatic do_load(input string tag, input int base, input int len, input int gap_pct);
    logic [7:0] b;
    int g;
    bus.load_start = 1'b1;
    bus.load_base  = 32'(base);
    bus.load_len   = 11'(len);
    tick();
    bus.load_start = 1'b0;
    if (len == 0) begin
      chk({tag, "_zdone"}, 32'(bus.load_done), 32'd1);
      chk({tag, "_zbusy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_zready"}, 32'(bus.load_ready), 32'd0);
      tick();
      chk({tag, "_zdone_end"}, 32'(bus.load_done), 32'd0);
      chk({tag, "_zbusy_end"}, 32'(bus.busy), 32'd0);
      return;
    end
    chk({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < len; i++) begin
      g = 0;
      while (g < 3 && $urandom_range(0, 99) < 32'(gap_pct)) begin
        bus.load_valid = 1'b0;
        tick();
        chk({tag, "_gap_done"}, 32'(bus.load_done), 32'd0);
        chk({tag, "_gap_ready"}, 32'(bus.load_ready), 32'd1);
        g++;
      end
      b = (lq.size() > 0) ? lq.pop_front() : 8'($urandom);
      bus.load_valid = 1'b1;
      bus.load_byte  = b;
      tick();
      model[(base + i) % MS] = b;
      known[(base + i) % MS] = 1'b1;
      if (i < len - 1) chk({tag, "_mid_done"}, 32'(bus.load_done), 32'd0);
    end
    bus.load_valid = 1'b0;
    chk({tag, "_done"}, 32'(bus.load_done), 32'd1);
    chk({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_done_ready"}, 32'(bus.load_ready), 32'd0);
    tick();
    chk({tag, "_done_end"}, 32'(bus.load_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base, len;
    for (int i = 0; i < MS; i++) begin model[i] = 8'h00; known[i] = 1'b0; end
    bus.load_start = 1'b0; bus.load_base = '0; bus.load_len = '0;
    bus.load_valid = 1'b0; bus.load_byte = '0;
    bus.fetch_req  = 1'b0; bus.fetch_addr = '0;

    // Reset for two cycles and check reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fvalid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_instr", bus.instruction, 32'd0);
    chk("rst_misal", 32'(bus.fetch_misaligned), 32'd0);
    rst = 1'b0;
    boot_model();

    // Boot word fetch
    fq = '{0};
    fetch_queue("boot");
    chk("boot_word", bus.instruction, 32'h8020000A);
    tick();
    chk("boot_idle_valid", 32'(bus.fetch_valid), 32'd0);

    // Fetch and load_start in the same IDLE cycle: fetch sees old contents
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'd0;
    bus.load_start = 1'b1; bus.load_base = 32'd0; bus.load_len = 11'd1;
    tick();
    bus.fetch_req = 1'b0; bus.load_start = 1'b0;
    chk("same_valid", 32'(bus.fetch_valid), 32'd1);
    chk("same_instr", bus.instruction, 32'h8020000A);
    chk("same_ready", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1; bus.load_byte = 8'h55;
    tick();
    model[0] = 8'h55;
    bus.load_valid = 1'b0;
    chk("same_done", 32'(bus.load_done), 32'd1);
    tick();
    fq = '{0};
    fetch_queue("same_post");
    chk("same_post_word", bus.instruction, 32'h80200055);

    // Load 01..08 at 0x10 with gaps, then back-to-back fetches
    lq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load("ld8", 32'h10, 8, 50);
    fq = '{32'h10, 32'h14};
    fetch_queue("ld8");
    chk("ld8_last", bus.instruction, 32'h08070605);

    // Wrap around the top of memory
    lq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load("wrap", 32'h3FE, 4, 0);
    fq = '{32'h3FE};
    fetch_queue("wrap");
    chk("wrap_word", bus.instruction, 32'hDDCCBBAA);
    chk("wrap_misal", 32'(bus.fetch_misaligned), 32'd1);

    // Fetches while busy are dropped; retry after busy falls
    bus.load_start = 1'b1; bus.load_base = 32'h40; bus.load_len = 11'd2;
    tick();
    bus.load_start = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40;
    bus.load_valid = 1'b1; bus.load_byte = 8'h66;
    tick();
    model[32'h40] = 8'h66; known[32'h40] = 1'b1;
    chk("busy_load_drop", 32'(bus.fetch_valid), 32'd0);
    bus.load_byte = 8'h77;
    tick();
    model[32'h41] = 8'h77; known[32'h41] = 1'b1;
    bus.load_valid = 1'b0;
    chk("busy_load_drop2", 32'(bus.fetch_valid), 32'd0);
    chk("busy_done", 32'(bus.load_done), 32'd1);
    tick();
    chk("busy_done_drop", 32'(bus.fetch_valid), 32'd0);
    chk("busy_fell", 32'(bus.busy), 32'd0);
    tick();
    bus.fetch_req = 1'b0;
    chk("busy_retry_valid", 32'(bus.fetch_valid), 32'd1);
    chk("busy_retry_lo16", 32'(bus.instruction[15:0]), 32'h7766);

    // Zero-length load leaves memory unchanged
    do_load("zero", 32'h10, 0, 0);
    fq = '{32'h10};
    fetch_queue("zero");

    // Randomized loads followed by pipelined fetches inside the loaded range
    for (int r = 0; r < 8; r++) begin
      base = int'($urandom_range(0, MS - 1));
      len  = int'($urandom_range(1, 12));
      do_load("rnd", base, len, 30);
      for (int k = 0; k < 3; k++) fq.push_back((base + int'($urandom_range(0, 32'(len - 1)))) % MS);
      fetch_queue("rnd");
    end

    // Reset in the middle of a load
    bus.load_start = 1'b1; bus.load_base = 32'h20; bus.load_len = 11'd4;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1; bus.load_byte = 8'h11;
    tick();
    bus.load_byte = 8'h22;
    tick();
    model[32'h20] = 8'h11; model[32'h21] = 8'h22;
    known[32'h20] = 1'b1; known[32'h21] = 1'b1;
    bus.load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    boot_model();
    chk("mid_rst_ready", 32'(bus.load_ready), 32'd0);
    chk("mid_rst_done", 32'(bus.load_done), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("mid_rst_nodone", 32'(bus.load_done), 32'd0);
    chk("mid_rst_ready2", 32'(bus.load_ready), 32'd0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h20;
    tick();
    bus.fetch_req = 1'b0;
    chk("mid_rst_valid", 32'(bus.fetch_valid), 32'd1);
    chk("mid_rst_lo16", 32'(bus.instruction[15:0]), 32'h2211);
    fq = '{0};
    fetch_queue("mid_rst_boot");
    chk("mid_rst_bootword", bus.instruction, 32'h8020000A);

    // Full-memory load from a random base, then random fetches anywhere
    do_load("full", int'($urandom_range(0, MS - 1)), MS, 0);
    for (int k = 0; k < 24; k++) fq.push_back(int'($urandom_range(0, MS - 1)));
    fetch_queue("full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
